// File: rtl/neo_stream_decoder.sv
// Receive-side decoder for a WS2812 (NeoPixel) single-wire stream sampled at 50 MHz.
// Classifies high pulses into bits, assembles GRB pixels, detects latch gaps and protocol errors.
module neo_stream_decoder #(
  parameter int NUM_PIXELS   = 5,
  parameter int MIN_HIGH     = 8,
  parameter int THRESH_HIGH  = 27,
  parameter int MAX_HIGH     = 50,
  parameter int RESET_CYCLES = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       neo_in,
  output logic       pixel_valid,
  output logic [2:0] pixel_index,
  output logic [7:0] green,
  output logic [7:0] red,
  output logic [7:0] blue,
  output logic       frame_done,
  output logic [3:0] pixel_count,
  output logic       overflow,
  output logic       error,
  output logic [1:0] error_code,
  output logic       busy
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] HIGH_MIN  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_ONE  = HW'(THRESH_HIGH);
  localparam logic [HW-1:0] HIGH_MAX  = HW'(MAX_HIGH);
  localparam logic [LW-1:0] LOW_LAST  = LW'(RESET_CYCLES - 1);
  localparam logic [3:0]    SLOTS     = 4'(NUM_PIXELS);
  localparam logic [4:0]    PIXEL_BITS = 5'd24;

  localparam logic [1:0] ERR_GLITCH  = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_PARTIAL = 2'b11;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t        state;
  logic          meta;
  logic          line;
  logic          line_d;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [23:0]   shift_reg;
  logic [4:0]    bit_cnt;
  logic [2:0]    slot;
  logic [3:0]    tally;

  logic rise;
  logic fall;

  assign rise = line & ~line_d;
  assign fall = ~line & line_d;
  assign busy = (state == ST_HIGH) || (state == ST_LOW);

  // NOTE: every register here is sequential state, so it is assigned with <= only;
  // blocking assignments would let later statements see half-updated values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_SYNC;
      meta        <= 1'b0;
      line        <= 1'b0;
      line_d      <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      slot        <= '0;
      tally       <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      green       <= '0;
      red         <= '0;
      blue        <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      error_code  <= '0;
    end else begin
      meta   <= neo_in;
      line   <= meta;
      line_d <= line;

      // NOTE: one-cycle strobes default low here and are raised only by the branch that fires them.
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      unique case (state)
        ST_SYNC: begin
          // Wait for a full latch gap of quiet line before trusting bit boundaries.
          if (line) begin
            low_cnt <= '0;
          end else if (low_cnt == LOW_LAST) begin
            low_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end

        ST_IDLE: begin
          if (rise) begin
            high_cnt <= HW'(1);
            overflow <= 1'b0;
            state    <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            if (high_cnt < HIGH_MIN) begin
              error      <= 1'b1;
              error_code <= ERR_GLITCH;
              shift_reg  <= '0;
              bit_cnt    <= '0;
              slot       <= '0;
              tally      <= '0;
              low_cnt    <= '0;
              state      <= ST_SYNC;
            end else begin
              shift_reg <= {shift_reg[22:0], (high_cnt >= HIGH_ONE)};
              bit_cnt   <= bit_cnt + 5'd1;
              low_cnt   <= LW'(1);
              state     <= ST_LOW;
            end
          end else if (high_cnt == HIGH_MAX) begin
            // Line is still high one cycle beyond the longest legal pulse.
            error      <= 1'b1;
            error_code <= ERR_LONG;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            slot       <= '0;
            tally      <= '0;
            low_cnt    <= '0;
            state      <= ST_SYNC;
          end else begin
            high_cnt <= high_cnt + HW'(1);
          end
        end

        ST_LOW: begin
          // A completed pixel is emitted in the first low cycle, independent of the next rise.
          if (bit_cnt == PIXEL_BITS) begin
            if ({1'b0, slot} < SLOTS) begin
              pixel_valid <= 1'b1;
              pixel_index <= slot;
              green       <= shift_reg[23:16];
              red         <= shift_reg[15:8];
              blue        <= shift_reg[7:0];
            end else begin
              overflow <= 1'b1;
            end
            bit_cnt <= '0;
            slot    <= (slot == 3'd7) ? slot : slot + 3'd1;
            tally   <= (tally == 4'd15) ? tally : tally + 4'd1;
          end

          if (rise) begin
            high_cnt <= HW'(1);
            state    <= ST_HIGH;
          end else if (low_cnt == LOW_LAST) begin
            frame_done  <= 1'b1;
            pixel_count <= tally;
            if (bit_cnt != 5'd0) begin
              error      <= 1'b1;
              error_code <= ERR_PARTIAL;
            end
            shift_reg <= '0;
            bit_cnt   <= '0;
            slot      <= '0;
            tally     <= '0;
            low_cnt   <= '0;
            state     <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule
